// File: rtl/program_loader_pkg.sv
// program_loader_pkg: shared state encoding and sizing helpers for the boot loader.
package program_loader_pkg;
  typedef enum logic [3:0] {IDLE, RX_LEN, RX_DATA, RX_CSUM, CLR, BURST, BOOT, RUN, ERR} state_e;
  localparam bit HI_FIRST = 1'b1;
  function automatic int addr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/loader_buf.sv
// loader_buf: simple dual-port sync RAM, one write port, one read port with 1-cycle latency.
module loader_buf #(
  parameter int DEPTH = 256,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [15:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [15:0]   rdata
);
  logic [15:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/program_loader.sv
// program_loader: receives a checksummed program image, then burst-loads the core and releases it.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int RST_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] programIN,
  output logic        LMin,
  output logic        core_reset,
  output logic        busy,
  output logic        done,
  output logic        error
);
  localparam int AW = addr_w(DEPTH);
  localparam int RW = $clog2(RST_CYCLES + 1);
  state_e state_q, state_d;
  logic hi_q, hi_d;
  logic [7:0] hold_q, hold_d;
  logic [AW-1:0] len_q, len_d, cnt_q, cnt_d, ptr_q, ptr_d;
  logic [15:0] csum_q, csum_d;
  logic [RW-1:0] rc_q, rc_d;
  logic in_ready_q, in_ready_d, lmin_q, lmin_d, core_reset_q, core_reset_d;
  logic busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic [15:0] prog_q, prog_d;
  logic acc, word_vld, we;
  logic [15:0] word, rd_data;

  loader_buf #(.DEPTH(DEPTH)) u_buf (
    .clk(clk),
    .we(we),
    .waddr(cnt_q[AW-2:0]),
    .wdata(word),
    .raddr(ptr_q[AW-2:0]),
    .rdata(rd_data)
  );

  always_comb begin
    acc = in_valid & in_ready_q;
    word = HI_FIRST ? {hold_q, in_byte} : {in_byte, hold_q};
    word_vld = acc & hi_q;
    hold_d = (acc & !hi_q) ? in_byte : hold_q;
    hi_d = acc ? !hi_q : hi_q;
    state_d = state_q;
    len_d = len_q;
    cnt_d = cnt_q;
    csum_d = csum_q;
    rc_d = rc_q;
    we = 1'b0;
    case (state_q)
      IDLE, RUN, ERR: if (start) state_d = RX_LEN;
      RX_LEN: if (word_vld) begin
        len_d = word[AW-1:0];
        csum_d = word;
        cnt_d = '0;
        state_d = (word == '0 || {1'b0, word} > 17'(DEPTH)) ? ERR : RX_DATA;
      end
      RX_DATA: if (word_vld) begin
        we = 1'b1;
        cnt_d = cnt_q + 1'b1;
        csum_d = csum_q ^ word;
        if (cnt_d == len_q) state_d = RX_CSUM;
      end
      RX_CSUM: if (word_vld) state_d = (word == csum_q) ? CLR : ERR;
      CLR: state_d = BURST;
      BURST: begin
        rc_d = RW'(RST_CYCLES - 1);
        if (ptr_q == len_q + 1'b1) state_d = BOOT;
      end
      BOOT: begin
        rc_d = rc_q - 1'b1;
        if (rc_q == '0) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
    // read pointer runs one word ahead so buffer[0] is already out when the burst starts
    ptr_d = (state_d == CLR || state_d == BURST) ? ptr_q + 1'b1 : '0;
    in_ready_d = state_d inside {RX_LEN, RX_DATA, RX_CSUM};
    lmin_d = state_d == BURST;
    core_reset_d = !(state_d == BURST || state_d == RUN);
    busy_d = !(state_d inside {IDLE, RUN, ERR});
    done_d = state_d == RUN;
    error_d = state_d == ERR;
    prog_d = lmin_d ? rd_data : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      hi_q <= 1'b0;
      hold_q <= '0;
      len_q <= '0;
      cnt_q <= '0;
      ptr_q <= '0;
      csum_q <= '0;
      rc_q <= '0;
      in_ready_q <= 1'b0;
      lmin_q <= 1'b0;
      core_reset_q <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      error_q <= 1'b0;
      prog_q <= '0;
    end else begin
      state_q <= state_d;
      hi_q <= hi_d;
      hold_q <= hold_d;
      len_q <= len_d;
      cnt_q <= cnt_d;
      ptr_q <= ptr_d;
      csum_q <= csum_d;
      rc_q <= rc_d;
      in_ready_q <= in_ready_d;
      lmin_q <= lmin_d;
      core_reset_q <= core_reset_d;
      busy_q <= busy_d;
      done_q <= done_d;
      error_q <= error_d;
      prog_q <= prog_d;
    end
  end

  assign in_ready = in_ready_q;
  assign programIN = prog_q;
  assign LMin = lmin_q;
  assign core_reset = core_reset_q;
  assign busy = busy_q;
  assign done = done_q;
  assign error = error_q;
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed image loads with a scoreboard of expected burst words.
module tb_program_loader;
  localparam int DEPTH = 256;
  localparam int RST_CYCLES = 2;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, in_valid = 1'b0;
  logic [7:0] in_byte = 8'h00;
  logic in_ready, LMin, core_reset, busy, done, error;
  logic [15:0] programIN;
  int checks = 0, errors = 0;
  logic [15:0] sb[$];
  logic [15:0] img[$];

  always #5 clk = ~clk;

  program_loader #(.DEPTH(DEPTH), .RST_CYCLES(RST_CYCLES)) dut (
    .clk(clk), .reset(reset), .start(start), .in_byte(in_byte), .in_valid(in_valid),
    .in_ready(in_ready), .programIN(programIN), .LMin(LMin), .core_reset(core_reset),
    .busy(busy), .done(done), .error(error)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // each load-enable cycle must present the next expected word; otherwise programIN is 0
  always @(negedge clk) begin
    if (LMin) begin
      if (sb.size() == 0) chk("lmin_unexpected", 32'(LMin), 0);
      else chk("programIN", 32'(programIN), 32'(sb.pop_front()));
    end else chk("programIN_idle", 32'(programIN), 0);
  end

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n;
    n = 0;
    if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
    in_byte = b;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("accept_timeout", 32'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_img(input bit gaps, input bit push, input bit poke);
    for (int i = 0; i < img.size(); i++) begin
      if (push && i > 0 && i < img.size() - 1) sb.push_back(img[i]);
      chk("rx_core_reset", 32'(core_reset), 1);
      if (poke && i == 2) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("poke_busy", 32'(busy), 1);
        chk("poke_ready", 32'(in_ready), 1);
      end
      send_byte(img[i][15:8], gaps);
      send_byte(img[i][7:0], gaps);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_boot(input int len);
    chk("clr_core_reset", 32'(core_reset), 1);
    chk("clr_lmin", 32'(LMin), 0);
    chk("clr_ready", 32'(in_ready), 0);
    repeat (len) begin
      @(negedge clk);
      chk("burst_lmin", 32'(LMin), 1);
      chk("burst_core_reset", 32'(core_reset), 0);
    end
    repeat (RST_CYCLES) begin
      @(negedge clk);
      chk("boot_lmin", 32'(LMin), 0);
      chk("boot_core_reset", 32'(core_reset), 1);
    end
    @(negedge clk);
    chk("run_done", 32'(done), 1);
    chk("run_core_reset", 32'(core_reset), 0);
    chk("run_busy", 32'(busy), 0);
    chk("sb_empty", 32'(sb.size()), 0);
  endtask

  initial begin
    logic [15:0] c, w;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(in_ready), 0);
    chk("rst_lmin", 32'(LMin), 0);
    chk("rst_core_reset", 32'(core_reset), 1);
    chk("rst_flags", {29'd0, busy, done, error}, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_core_reset", 32'(core_reset), 1);
    chk("idle_ready", 32'(in_ready), 0);
    img = '{16'h0006, 16'h0005, 16'hec10, 16'h0001, 16'he308, 16'h0000, 16'he007, 16'hef1d};
    pulse_start();
    chk("rx_ready", 32'(in_ready), 1);
    chk("rx_busy", 32'(busy), 1);
    send_img(1'b0, 1'b1, 1'b0);
    check_boot(6);
    img[7] = 16'hef1c;
    pulse_start();
    chk("restart_done", 32'(done), 0);
    chk("restart_core_reset", 32'(core_reset), 1);
    send_img(1'b0, 1'b0, 1'b0);
    chk("bad_csum_error", 32'(error), 1);
    chk("bad_csum_ready", 32'(in_ready), 0);
    repeat (4) @(negedge clk);
    chk("err_core_reset", 32'(core_reset), 1);
    chk("err_hold", 32'(error), 1);
    img = '{16'h0000};
    pulse_start();
    chk("err_clear", 32'(error), 0);
    send_img(1'b0, 1'b0, 1'b0);
    chk("len0_error", 32'(error), 1);
    in_byte = 8'h55;
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("err_no_consume", 32'(in_ready), 0);
    end
    in_valid = 1'b0;
    img = '{16'h0101};
    pulse_start();
    send_img(1'b0, 1'b0, 1'b0);
    chk("len_big_error", 32'(error), 1);
    img = '{16'h0100};
    c = 16'h0100;
    for (int i = 0; i < DEPTH; i++) begin
      w = 16'($urandom);
      img.push_back(w);
      c = c ^ w;
    end
    img.push_back(c);
    pulse_start();
    send_img(1'b0, 1'b1, 1'b0);
    check_boot(DEPTH);
    img = '{16'h0006, 16'h0005, 16'hec10, 16'h0001, 16'he308, 16'h0000, 16'he007, 16'hef1d};
    pulse_start();
    send_img(1'b1, 1'b1, 1'b1);
    check_boot(6);
    pulse_start();
    chk("run_restart_done", 32'(done), 0);
    chk("run_restart_core_reset", 32'(core_reset), 1);
    img = '{16'h0001, 16'habcd, 16'habcc};
    send_img(1'b0, 1'b1, 1'b0);
    check_boot(1);
    img = '{16'h0006, 16'h0005, 16'hec10, 16'h0001, 16'he308, 16'h0000, 16'he007, 16'hef1d};
    pulse_start();
    send_img(1'b0, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    chk("mid_burst_lmin", 32'(LMin), 1);
    reset = 1'b1;
    @(negedge clk);
    sb.delete();
    chk("abort_lmin", 32'(LMin), 0);
    chk("abort_core_reset", 32'(core_reset), 1);
    chk("abort_flags", {28'd0, in_ready, busy, done, error}, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_idle", {29'd0, core_reset, busy, in_ready}, 32'h4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
